// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: op codes, FSM states
// and the op-code decode helpers.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIVS = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_MODS = 2'd2,
    DIV_OP_MODU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIT   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ABORT = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIVS) || (op == DIV_OP_MODS);
  endfunction

  function automatic logic op_sel_rem(input logic [1:0] op);
    return (op == DIV_OP_MODS) || (op == DIV_OP_MODU);
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU/MOD/MODU requests to the multicycle divider, stalls EX until
// the result returns, and keeps a one-entry cache of the last divide.
//
// state    | meaning
// ST_IDLE  | no divide outstanding; accepts a new request
// ST_HIT   | cached result is being returned (result_valid high)
// ST_WAIT  | divide in flight, result wanted by EX
// ST_ABORT | divide in flight for a flushed op; result only fills the cache
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  input  logic [1:0]            i_req_op,
  input  logic [DATA_WIDTH-1:0] i_req_a,
  input  logic [DATA_WIDTH-1:0] i_req_b,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_result_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_div_a,
  output logic [DATA_WIDTH-1:0] o_div_b,
  output logic                  o_div_is_signed,
  output logic                  o_div_start,
  input  logic [DATA_WIDTH-1:0] i_div_quotient,
  input  logic [DATA_WIDTH-1:0] i_div_remainder,
  input  logic                  i_div_done
);

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic                  r_result_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_div_a;
  logic [DATA_WIDTH-1:0] r_div_b;
  logic                  r_div_is_signed;
  logic                  r_div_start;
  logic                  r_sel_rem;

  logic                  r_cache_valid;
  logic [DATA_WIDTH-1:0] r_tag_a;
  logic [DATA_WIDTH-1:0] r_tag_b;
  logic                  r_tag_signed;
  logic [DATA_WIDTH-1:0] r_cache_quo;
  logic [DATA_WIDTH-1:0] r_cache_rem;

  logic w_signed;
  logic w_sel_rem;
  logic w_hit;
  logic w_accept;
  logic w_issue;
  logic w_take_hit;
  logic w_fill;
  logic w_deliver;

  assign w_signed  = op_is_signed(i_req_op);
  assign w_sel_rem = op_sel_rem(i_req_op);
  assign w_hit     = r_cache_valid && (r_tag_a == i_req_a) && (r_tag_b == i_req_b)
                     && (r_tag_signed == w_signed);
  // The cycle a result is returned, EX still shows the finishing op; it must
  // not be taken as a new request.
  assign w_accept  = i_req_valid && !i_flush && !r_result_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_take_hit  = 1'b0;
    w_fill      = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_take_hit  = 1'b1;
            w_state_nxt = ST_HIT;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_HIT: w_state_nxt = ST_IDLE;
      ST_WAIT: begin
        // A flush landing on the done cycle squashes the result but still caches it.
        if (i_div_done) begin
          w_fill      = 1'b1;
          w_deliver   = !i_flush;
          w_state_nxt = ST_IDLE;
        end else if (i_flush) begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (i_div_done) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_result_valid  <= 1'b0;
      r_result        <= '0;
      r_div_a         <= '0;
      r_div_b         <= '0;
      r_div_is_signed <= 1'b0;
      r_div_start     <= 1'b0;
      r_sel_rem       <= 1'b0;
      r_cache_valid   <= 1'b0;
      r_tag_a         <= '0;
      r_tag_b         <= '0;
      r_tag_signed    <= 1'b0;
      r_cache_quo     <= '0;
      r_cache_rem     <= '0;
    end else begin
      r_result_valid <= w_take_hit || w_deliver;
      r_div_start    <= w_issue;
      if (w_issue) begin
        r_div_a         <= i_req_a;
        r_div_b         <= i_req_b;
        r_div_is_signed <= w_signed;
        r_sel_rem       <= w_sel_rem;
      end
      if (w_take_hit)
        r_result <= w_sel_rem ? r_cache_rem : r_cache_quo;
      else if (w_deliver)
        r_result <= r_sel_rem ? i_div_remainder : i_div_quotient;
      // Divider operands stay stable while it runs, so they are the cache tag.
      if (w_fill) begin
        r_cache_valid <= 1'b1;
        r_tag_a       <= r_div_a;
        r_tag_b       <= r_div_b;
        r_tag_signed  <= r_div_is_signed;
        r_cache_quo   <= i_div_quotient;
        r_cache_rem   <= i_div_remainder;
      end
    end
  end

  assign o_stall         = i_req_valid && !r_result_valid && !i_flush && !i_reset;
  assign o_result_valid  = r_result_valid;
  assign o_result        = r_result;
  assign o_div_a         = r_div_a;
  assign o_div_b         = r_div_b;
  assign o_div_is_signed = r_div_is_signed;
  assign o_div_start     = r_div_start;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider plus a transaction-level
// model of the controller compared every cycle, and directed literal cases.
`timescale 1ns/1ps
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         flush;
  logic         stall, result_valid, div_is_signed, div_start, div_done;
  logic [W-1:0] result, div_a, div_b, div_quotient, div_remainder;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b), .i_flush(flush),
    .o_stall(stall), .o_result_valid(result_valid), .o_result(result),
    .o_div_a(div_a), .o_div_b(div_b), .o_div_is_signed(div_is_signed),
    .o_div_start(div_start), .i_div_quotient(div_quotient),
    .i_div_remainder(div_remainder), .i_div_done(div_done)
  );

  // {quotient, remainder} with divide-by-zero and signed-overflow semantics
  function automatic logic [2*W-1:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sg);
    longint la, lb, q, r;
    if (b == '0) return {{W{1'b1}}, a};
    la = sg ? longint'($signed(a)) : longint'(a);
    lb = sg ? longint'($signed(b)) : longint'(b);
    q  = la / lb;
    r  = la % lb;
    return {q[W-1:0], r[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider: done 33 cycles after start; divide-by-zero answers in the start cycle.
  logic [W-1:0] dv_q, dv_r;
  logic         dv_done_r;
  int           dv_cnt;
  logic         dv_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_cnt    <= 0;
      dv_done_r <= 1'b0;
      dv_q      <= '0;
      dv_r      <= '0;
    end else begin
      dv_done_r <= 1'b0;
      if (div_start && div_b != '0) begin
        dv_cnt       <= W;
        {dv_q, dv_r} <= div_ref(div_a, div_b, div_is_signed);
      end else if (dv_cnt > 0) begin
        dv_cnt <= dv_cnt - 1;
        if (dv_cnt == 1) dv_done_r <= 1'b1;
      end
    end
  end

  assign dv_zero       = div_start && (div_b == '0);
  assign div_done      = dv_done_r || dv_zero;
  assign div_quotient  = dv_zero ? '1 : dv_q;
  assign div_remainder = dv_zero ? div_a : dv_r;

  // Controller model: busy/want flags for the outstanding divide, results from div_ref.
  logic         m_busy, m_want, m_rv, m_start, m_sg, m_sel;
  logic [W-1:0] m_res, m_a, m_b;
  logic         c_valid, c_sg;
  logic [W-1:0] c_a, c_b, c_q, c_r;
  logic         t_rv, t_start, t_sg, t_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_want = 0; m_rv = 0; m_start = 0; m_sg = 0; m_sel = 0;
      m_res = '0; m_a = '0; m_b = '0;
      c_valid = 0; c_sg = 0; c_a = '0; c_b = '0; c_q = '0; c_r = '0;
    end else begin
      t_rv = 0; t_start = 0;
      if (m_busy) begin
        if (div_done) begin
          {c_q, c_r} = div_ref(m_a, m_b, m_sg);
          c_valid = 1; c_a = m_a; c_b = m_b; c_sg = m_sg;
          if (m_want && !flush) begin
            t_rv  = 1;
            m_res = m_sel ? c_r : c_q;
          end
          m_busy = 0;
        end else if (flush) begin
          m_want = 0;
        end
      end else if (req_valid && !flush && !m_rv) begin
        t_sg  = ~req_op[0];
        t_sel = req_op[1];
        if (c_valid && c_a == req_a && c_b == req_b && c_sg == t_sg) begin
          t_rv  = 1;
          m_res = t_sel ? c_r : c_q;
        end else begin
          t_start = 1;
          m_a = req_a; m_b = req_b; m_sg = t_sg; m_sel = t_sel;
          m_busy = 1; m_want = 1;
        end
      end
      m_rv    = t_rv;
      m_start = t_start;
    end
  end

  always @(negedge clk) begin
    chk("stall", W'(stall), W'(req_valid && !m_rv && !flush && !rst));
    chk("result_valid", W'(result_valid), W'(m_rv));
    chk("result", result, m_res);
    chk("div_start", W'(div_start), W'(m_start));
    chk("div_a", div_a, m_a);
    chk("div_b", div_b, m_b);
    chk("div_is_signed", W'(div_is_signed), W'(m_sg));
  end

  // Present one op (called just after a rising edge) and check result, latency, starts.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input int exp_lat, input int exp_starts);
    int  k, starts;
    bit  seen;
    req_valid = 1; req_op = op; req_a = a; req_b = b; flush = 0;
    k = 0; starts = 0; seen = 0;
    while (k < 200 && !seen) begin
      @(negedge clk);
      if (div_start) starts++;
      if (result_valid) seen = 1;
      else k++;
    end
    chk({name, "_seen"}, W'(seen), W'(1));
    chk({name, "_latency"}, W'(k), W'(exp_lat));
    chk({name, "_result"}, result, exp_res);
    chk({name, "_starts"}, W'(starts), W'(exp_starts));
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           k, starts, rv_seen;
    bit           have, adv;
    logic [W-1:0] pool [6];

    rst = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result_valid", W'(result_valid), W'(0));
    chk("reset_div_start", W'(div_start), W'(0));
    chk("reset_result", result, '0);
    rst = 0;
    @(posedge clk); #1;

    run_op("divs_m7_2", DIV_OP_DIVS, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, 1);
    run_op("mods_m7_2_hit", DIV_OP_MODS, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1, 0);
    run_op("divu_m7_2", DIV_OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 35, 1);
    run_op("divs_5_0", DIV_OP_DIVS, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 1);
    run_op("mods_5_0_hit", DIV_OP_MODS, 32'd5, 32'd0, 32'd5, 1, 0);

    // MODU 100/7 flushed 5 cycles in; the next op waits out the orphaned divide.
    req_valid = 1; req_op = DIV_OP_MODU; req_a = 32'd100; req_b = 32'd7;
    rv_seen = 0;
    repeat (5) begin
      @(negedge clk); if (result_valid) rv_seen++;
      @(posedge clk); #1;
    end
    flush = 1;
    @(negedge clk); if (result_valid) rv_seen++;
    @(posedge clk); #1;
    chk("flush_no_result", W'(rv_seen), W'(0));
    run_op("divu_9_3_after_abort", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 64, 1);
    // The cache now holds 9/3, so this re-runs the divider.
    run_op("modu_100_7", DIV_OP_MODU, 32'd100, 32'd7, 32'd2, 35, 1);

    // Asynchronous reset in the middle of a divide.
    req_valid = 1; req_op = DIV_OP_DIVS; req_a = 32'd100; req_b = 32'd7;
    repeat (10) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_stall", W'(stall), W'(0));
    chk("arst_div_a", div_a, '0);
    chk("arst_div_b", div_b, '0);
    chk("arst_signed", W'(div_is_signed), W'(0));
    req_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    run_op("divs_100_7_after_reset", DIV_OP_DIVS, 32'd100, 32'd7, 32'd14, 35, 1);

    // Random traffic; operand pool and reuse drive both hits and misses.
    pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFFFFFF;
    pool[3] = 32'd7; pool[4] = 32'h80000000; pool[5] = 32'd12345;
    have = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      adv = result_valid || flush;
      @(posedge clk); #1;
      if (have && adv) have = 0;
      flush = 0;
      if (!have && $urandom_range(0, 3) == 0) begin
        have   = 1;
        req_op = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin
          req_a = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
          req_b = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
        end
      end
      req_valid = have;
      if (have && $urandom_range(0, 29) == 0) flush = 1;
    end

    req_valid = 0; flush = 0;
    repeat (40) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
